// File: rtl/scaled_seq_pkg.sv
// Shared types and constants for the scaled clock sequencer.
// Imported by scaled_clock_seq.
package scaled_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_DIV_DEFAULT = 49;

endpackage

// File: rtl/scaled_div_core.sv
// Divide counter: counts qualified cycles, toggles scaledclk and pulses
// tick one cycle after each terminal count; clr restarts it synchronously.
module scaled_div_core #(
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] counter,
  output logic             scaledclk,
  output logic             tick,
  output logic             term
);

  assign term = en && (counter == div);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter   <= '0;
      scaledclk <= 1'b0;
      tick      <= 1'b0;
    end else if (clr) begin
      counter   <= '0;
      scaledclk <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= term;
      if (term) begin
        counter   <= '0;
        scaledclk <= ~scaledclk;
      end else if (en) begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/scaled_clock_seq.sv
// Run-controlled clock divider with start/stop/pause and a tick limit.
// Define SCALED_SEQ_AUTORELOAD_EN to restart the tick count instead of ending.
module scaled_clock_seq
  import scaled_seq_pkg::*;
#(
  parameter int CNT_W   = 7,
  parameter int DEF_DIV = DEF_DIV_DEFAULT,
  parameter int TCNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [TCNT_W-1:0] cfg_ticks,
  output logic [CNT_W-1:0]  counter,
  output logic              scaledclk,
  output logic              tick,
  output logic              busy,
  output logic              done
);

`ifdef SCALED_SEQ_AUTORELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  seq_state_t        state;
  seq_state_t        state_n;
  logic [CNT_W-1:0]  div;
  logic [TCNT_W-1:0] limit;
  logic [TCNT_W-1:0] tcnt;
  logic              idle_like;
  logic              launch;
  logic              run_en;
  logic              clr;
  logic              term;
  logic              hit;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign busy      = (state == RUN) || (state == PAUSE);
  assign done      = (state == DONE);
  assign cfg_ready = idle_like;

  // stop outranks start, pause and a coincident terminal count
  assign launch = idle_like && start && !stop;
  assign run_en = (state == RUN) && enable && !stop;
  assign clr    = launch || (busy && stop);
  assign hit    = term && (limit != '0) &&
                  ((tcnt + TCNT_W'(1)) == limit);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (launch) state_n = RUN;
      end
      RUN: begin
        if (stop)
          state_n = IDLE;
        else if (hit && !AUTO_RELOAD)
          state_n = DONE;
        else if (pause)
          state_n = PAUSE;
      end
      PAUSE: begin
        if (stop)
          state_n = IDLE;
        else if (!pause)
          state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div   <= CNT_W'(DEF_DIV);
      limit <= '0;
    end else if (cfg_valid && cfg_ready) begin
      div   <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
      limit <= cfg_ticks;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      tcnt <= '0;
    else if (clr)
      tcnt <= '0;
    else if (term)
      tcnt <= (hit && AUTO_RELOAD) ? '0 : tcnt + TCNT_W'(1);
  end

  scaled_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (run_en),
    .clr       (clr),
    .div       (div),
    .counter   (counter),
    .scaledclk (scaledclk),
    .tick      (tick),
    .term      (term)
  );

endmodule

// File: tb/tb_scaled_clock_seq.sv
// Bench for scaled_clock_seq: directed scenarios plus random run control,
// checked against a count-of-enabled-edges reference model.
module tb_scaled_clock_seq;

  localparam int CNT_W  = 7;
  localparam int TCNT_W = 16;
`ifdef SCALED_SEQ_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [TCNT_W-1:0] cfg_ticks = '0;
  logic              cfg_ready;
  logic [CNT_W-1:0]  counter;
  logic              scaledclk;
  logic              tick;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model: 0 idle, 1 run, 2 pause, 3 done; m_n counts enabled run edges
  int m_st, m_n, m_div, m_lim, m_cnt;
  bit m_sclk, m_tick;

  always #5 clock = ~clock;

  scaled_clock_seq dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_ticks (cfg_ticks),
    .counter   (counter),
    .scaledclk (scaledclk),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_n = 0; m_div = 49; m_lim = 0;
    m_cnt = 0; m_sclk = 0; m_tick = 0;
  endtask

  task automatic check_all();
    chk("counter", 32'(counter), 32'(m_cnt));
    chk("scaledclk", 32'(scaledclk), 32'(m_sclk));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("busy", 32'(busy), (m_st == 1 || m_st == 2) ? 1 : 0);
    chk("done", 32'(done), (m_st == 3) ? 1 : 0);
    chk("cfg_ready", 32'(cfg_ready), (m_st == 0 || m_st == 3) ? 1 : 0);
  endtask

  // advance model by the inputs present now, then clock the DUT and compare
  task automatic step();
    int k;
    m_tick = 0;
    if ((m_st == 0 || m_st == 3) && cfg_valid) begin
      m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
      m_lim = int'(cfg_ticks);
    end
    case (m_st)
      0, 3: if (start && !stop) begin
        m_st = 1; m_n = 0; m_cnt = 0; m_sclk = 0;
      end
      1: if (stop) begin
        m_st = 0; m_cnt = 0; m_sclk = 0;
      end else begin
        if (enable) begin
          m_n++;
          m_cnt = m_n % (m_div + 1);
          if (m_cnt == 0) begin
            k = m_n / (m_div + 1);
            m_tick = 1;
            m_sclk = (k % 2) == 1;
            if (m_lim != 0 && k == m_lim && !AUTO) m_st = 3;
          end
        end
        if (m_st == 1 && pause) m_st = 2;
      end
      2: if (stop) begin
        m_st = 0; m_cnt = 0; m_sclk = 0;
      end else if (!pause) m_st = 1;
      default: m_st = 0;
    endcase
    @(posedge clock);
    #1;
    cyc++;
    check_all();
  endtask

  // asynchronous reset applied between edges
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    @(posedge clock);
    #1 check_all();
    #2 reset_n = 1'b1;
  endtask

  task automatic cfg(input int d, input int t);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(d);
    cfg_ticks = TCNT_W'(t);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int s;
    int tq[$];

    m_reset();
    #1 check_all();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (3) step();

    // default divide, unlimited
    enable = 1'b1;
    go();
    s = cyc;
    tq = {};
    repeat (220) begin
      step();
      if (tick) tq.push_back(cyc);
    end
    chk("def_ntick", tq.size(), 4);
    if (tq.size() >= 2) begin
      chk("def_first", tq[0] - s, 50);
      chk("def_gap", tq[1] - tq[0], 50);
    end
    chk("def_busy", 32'(busy), 1);

    // reset mid-run discards the run
    do_reset();
    repeat (60) step();

    // stop together with start while running
    go();
    repeat (5) step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("stopstart_busy", 32'(busy), 0);
    repeat (3) step();

    // stop on the terminal-count cycle
    cfg(3, 0);
    go();
    for (int i = 0; i < 10 && m_cnt != 3; i++) step();
    chk("pre_term_cnt", 32'(counter), 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stopterm_tick", 32'(tick), 0);
    chk("stopterm_done", 32'(done), 0);
    repeat (3) step();

`ifndef SCALED_SEQ_AUTORELOAD_EN
    // bounded run ends with the fourth tick
    cfg(3, 4);
    go();
    tq = {};
    repeat (24) begin
      step();
      if (tick) begin
        tq.push_back(cyc);
        if (tq.size() == 4) chk("done_with_4th", 32'(done), 1);
      end
    end
    chk("bnd_ntick", tq.size(), 4);
    if (tq.size() == 4) chk("bnd_gap", tq[3] - tq[2], 4);
    chk("bnd_cfg_ready", 32'(cfg_ready), 1);
`endif

    // configuration offered while running is refused
    cfg(3, 0);
    go();
    repeat (2) step();
    cfg_valid = 1'b1;
    cfg_div   = 7'd7;
    cfg_ticks = 16'd1;
    #1 chk("run_cfg_ready", 32'(cfg_ready), 0);
    step();
    cfg_valid = 1'b0;
    tq = {};
    repeat (20) begin
      step();
      if (tick) tq.push_back(cyc);
    end
    chk("run_cfg_ntick", tq.size(), 5);
    if (tq.size() >= 2) chk("run_cfg_gap", tq[1] - tq[0], 4);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // pause and enable gaps delay the tick by exactly their length
    cfg(9, 0);
    go();
    s = cyc;
    for (int i = 0; i < 20 && m_cnt != 6; i++) step();
    chk("pause_at6", 32'(counter), 6);
    pause = 1'b1;
    repeat (5) step();
    pause = 1'b0;
    repeat (3) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    for (int i = 0; i < 30 && !tick; i++) step();
    chk("pause_delay", cyc - s, 18);
    stop = 1'b1;
    step();
    stop = 1'b0;

`ifdef SCALED_SEQ_AUTORELOAD_EN
    // limit reached: tick count restarts, run continues
    cfg(1, 2);
    go();
    tq = {};
    repeat (20) begin
      step();
      if (tick) tq.push_back(cyc);
    end
    chk("auto_ntick", tq.size(), 10);
    chk("auto_done", 32'(done), 0);
    chk("auto_busy", 32'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
`endif

    // random run control against the model
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset();
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      pause     = ($urandom_range(0, 9) == 0) ? ~pause : pause;
      enable    = ($urandom_range(0, 7) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 5));
      cfg_ticks = TCNT_W'($urandom_range(0, 5));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scaled_clock_seq.md
SCALED_CLOCK_SEQ -- requirements
Module: scaled_clock_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 7, width of the divide counter.
REQ-002 SHALL have parameter DEF_DIV, default 49, terminal count after reset.
REQ-003 SHALL have parameter TCNT_W, default 16, width of the tick-count limit.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  count qualifier; counter advances only while high.
REQ-007 SHALL have port start  in  1  one-cycle request to begin a run.
REQ-008 SHALL have port stop  in  1  one-cycle request to abort a run.
REQ-009 SHALL have port pause  in  1  level; holds the run while high.
REQ-010 SHALL have port cfg_valid  in  1  configuration offered.
REQ-011 SHALL have port cfg_ready  out  1  configuration accepted this cycle if cfg_valid high.
REQ-012 SHALL have port cfg_div  in  CNT_W  new terminal count.
REQ-013 SHALL have port cfg_ticks  in  TCNT_W  ticks per run; 0 = unlimited.
REQ-014 SHALL have port counter  out  CNT_W  live divide counter.
REQ-015 SHALL have port scaledclk  out  1  divided clock, toggles at each terminal count.
REQ-016 SHALL have port tick  out  1  one-cycle pulse at each terminal count.
REQ-017 SHALL have port busy  out  1  high in RUN or PAUSE.
REQ-018 SHALL have port done  out  1  high while in DONE.

Function
REQ-019 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-020 SHALL drive cfg_ready high only in IDLE or DONE; on cfg_valid&&cfg_ready, latch cfg_div and cfg_ticks at that edge; cfg_div of 0 latched as 1.
REQ-021 SHALL go IDLE/DONE -> RUN on start, clearing counter and tick count and setting scaledclk to 0 at that edge; start in RUN/PAUSE is ignored.
REQ-022 SHALL, in RUN with enable high, increment counter each cycle; when counter equals the latched div, set counter to 0, toggle scaledclk, pulse tick for exactly one cycle, increment the tick count.
REQ-023 SHALL hold counter and scaledclk and suppress tick while enable is low or while in PAUSE.
REQ-024 SHALL give scaledclk a period of 2*(div+1) enabled cycles; first tick is high in the cycle after the edge that is div+1 enabled edges after the start edge.
REQ-025 SHALL go RUN -> PAUSE while pause high, PAUSE -> RUN when pause low, with no lost or extra counts.
REQ-026 SHALL, when the tick count reaches a nonzero cfg_ticks, go RUN -> DONE on the same edge as that tick; scaledclk and counter then hold.
REQ-027 SHALL go RUN/PAUSE -> IDLE on stop, forcing counter 0 and scaledclk 0; stop beats start, pause and a coincident terminal count (no tick, no DONE).
REQ-028 SHALL make cfg_ticks=0 run until stop.

Reset
REQ-029 SHALL, while reset_n low, force state IDLE, counter 0, scaledclk 0, tick 0, busy 0, done 0, cfg_ready 1, div=DEF_DIV, ticks limit 0, regardless of clock.
REQ-030 SHALL discard an in-progress run on reset assertion; no tick follows release until a new start.

Configuration
REQ-031 SHALL honour macro SCALED_SEQ_AUTORELOAD_EN: when defined, reaching the tick limit clears the tick count and stays in RUN (done never asserts, busy stays high); when undefined, behaviour is REQ-026.

Structure
REQ-032 SHALL place the state enum type and the DEF_DIV default constant in package scaled_seq_pkg.
REQ-033 SHALL instantiate one sub-module scaled_div_core (counter, compare, scaledclk toggle, tick) driven by a run-qualified enable and a synchronous clear from the FSM.

Verification
REQ-034 SHALL cover reset defaults: reset_n low mid-run -> counter 0, scaledclk 0, done 0, busy 0, cfg_ready 1 immediately.
REQ-035 SHALL cover default divide: start, enable=1, div=49, ticks=0 -> tick every 50 cycles, scaledclk period 100, busy stays 1.
REQ-036 SHALL cover bounded run: cfg div=3, ticks=4, start -> 4 ticks 4 cycles apart, done rises with 4th tick, cfg_ready 1 after.
REQ-037 SHALL cover pause/enable gaps: div=9, pause 5 cycles at counter=6 plus enable low 3 cycles -> tick delayed exactly 8 cycles.
REQ-038 SHALL cover collisions: stop with start, and stop on terminal-count cycle -> IDLE, no tick, done 0; cfg_valid during RUN -> cfg_ready 0, div unchanged.
REQ-039 SHALL cover macro: with SCALED_SEQ_AUTORELOAD_EN, div=1, ticks=2 -> ticks continue past 2, done stays 0.
